// File: rtl/phase2speed_pkg.sv
// Shared widths, fixed-point formats and output saturation for the
// phase-to-speed converter.
package phase2speed_pkg;

    // Phase input: Q3.16 radians, 19 bits signed.
    localparam int PHASE_W    = 19;
    localparam int PHASE_FRAC = 16;

    // Speed output: Q6.10, 16 bits signed.
    localparam int SPEED_W    = 16;
    localparam int SPEED_FRAC = 10;

    // Scale factor: unsigned Q8.10.
    localparam int SCALE_W    = 18;
    localparam int SCALE_FRAC = 10;

    // Signed phase times unsigned scale (zero-extended to SCALE_W+1 bits
    // so it can enter a signed multiply): Q11.26 in 37 bits.
    localparam int PROD_W     = PHASE_W + SCALE_W;

    // Right shift that takes the Q.26 product back to Q.10.
    localparam int SHIFT_Q10  = PHASE_FRAC + SCALE_FRAC - SPEED_FRAC;

    // Output saturation limits (32767 and -32768).
    localparam logic signed [SPEED_W-1:0] SPEED_MAX = 16'sh7FFF;
    localparam logic signed [SPEED_W-1:0] SPEED_MIN = 16'sh8000;

    // Clamp a full-width scaled product into the 16-bit speed range.
    function automatic logic signed [SPEED_W-1:0] sat_speed(
        input logic signed [PROD_W-1:0] v
    );
        if (v > PROD_W'(SPEED_MAX)) begin
            return SPEED_MAX;
        end else if (v < PROD_W'(SPEED_MIN)) begin
            return SPEED_MIN;
        end else begin
            return v[SPEED_W-1:0];
        end
    endfunction

endpackage

// File: rtl/phase2speed_block_avg.sv
// Block averager: sums 2^N qualified phase samples and emits their floored
// mean together with a one-cycle valid flag.
module phase_block_avg
    import phase2speed_pkg::*;
#(
    parameter int N = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_sample,
    input  logic signed [PHASE_W-1:0] i_phase,
    output logic signed [PHASE_W-1:0] o_avg,
    output logic                      o_avg_valid
);

    // N guard bits: the sum of 2^N samples can never overflow.
    localparam int ACC_W = PHASE_W + N;
    // The counter keeps at least one bit so N=0 stays legal.
    localparam int CNT_W = (N > 0) ? N : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << N) - 1);

    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [PHASE_W-1:0] r_avg;
    logic                      r_valid;

    logic signed [ACC_W-1:0]   w_phase_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_last;

    // Signed-to-wider-signed assignment sign-extends the phase.
    assign w_phase_ext = i_phase;
    assign w_sum       = r_acc + w_phase_ext;
    assign w_last      = (r_cnt == LAST);

    // Running sum, position in the block and the stage-1 valid pulse.
    always_ff @(posedge i_clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!i_reset_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_sample) begin
                if (w_last) begin
                    // Restart immediately so the next sample opens a new block.
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Capture the floored block mean when the last sample of a block arrives.
    always_ff @(posedge i_clock) begin
        // NOTE: pure data register with no reset; it is only ever consumed
        // alongside r_valid, which is reset.
        if (i_sample && w_last) begin
            r_avg <= PHASE_W'(w_sum >>> N);
        end
    end

    assign o_avg       = r_avg;
    assign o_avg_valid = r_valid;

endmodule

// File: rtl/phase2speed.sv
// Phase-difference to speed converter: block average, constant scaling,
// 16-bit saturation and a ready pulse per result.
module phase2speed
    import phase2speed_pkg::*;
#(
    parameter int          N     = 1,
    parameter int unsigned SCALE = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample,
    input  logic [PHASE_W-1:0] phase,
    output logic [SPEED_W-1:0] speed,
    output logic               ready
);

    localparam logic [SCALE_W-1:0] SCALE_Q = SCALE_W'(SCALE);

    logic signed [PHASE_W-1:0] w_avg;
    logic                      w_avg_valid;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_prod_q10;
    logic signed [SPEED_W-1:0] w_speed_sat;

    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_prod_valid;

    phase_block_avg #(
        .N (N)
    ) u_block_avg (
        .i_clock     (clock),
        .i_reset_n   (reset),
        .i_sample    (sample),
        .i_phase     ($signed(phase)),
        .o_avg       (w_avg),
        .o_avg_valid (w_avg_valid)
    );

    // Scale is zero-extended by one bit so the signed multiply treats it as
    // positive; both operands are widened to the full product width first.
    assign w_prod      = PROD_W'(w_avg) * PROD_W'($signed({1'b0, SCALE_Q}));
    assign w_prod_q10  = r_prod >>> SHIFT_Q10;
    assign w_speed_sat = sat_speed(w_prod_q10);

    // Stage-2 valid flag follows the averager's valid pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prod_valid <= 1'b0;
        end else begin
            r_prod_valid <= w_avg_valid;
        end
    end

    // Register the scaled product for each new block average.
    always_ff @(posedge clock) begin
        if (w_avg_valid) begin
            r_prod <= w_prod;
        end
    end

    // Output stage: saturated speed held between updates, one-cycle ready.
    always_ff @(posedge clock) begin
        if (!reset) begin
            speed <= '0;
            ready <= 1'b0;
        end else begin
            ready <= r_prod_valid;
            if (r_prod_valid) begin
                speed <= w_speed_sat;
            end
        end
    end

endmodule

// File: tb/tb_phase2speed.sv
// Self-checking bench for phase2speed: directed block tests on N=1,
// saturation on N=0 with a large scale, continuous streaming on N=0 and a
// randomized gapped stream on N=3 checked against an arithmetic model.
module tb_phase2speed;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_a, rst_x;
    logic        sa, sb, sc, sd;
    logic [18:0] pa, pb, pc, pd;
    logic [15:0] spd_a, spd_b, spd_c, spd_d;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;

    int n_checks = 0;
    int n_fails  = 0;

    phase2speed #(.N(1), .SCALE(1024)) u_a (
        .clock(clock), .reset(rst_a), .sample(sa), .phase(pa), .speed(spd_a), .ready(rdy_a));
    phase2speed #(.N(0), .SCALE(262143)) u_b (
        .clock(clock), .reset(rst_x), .sample(sb), .phase(pb), .speed(spd_b), .ready(rdy_b));
    phase2speed #(.N(0), .SCALE(1024)) u_c (
        .clock(clock), .reset(rst_x), .sample(sc), .phase(pc), .speed(spd_c), .ready(rdy_c));
    phase2speed #(.N(3), .SCALE(131072)) u_d (
        .clock(clock), .reset(rst_x), .sample(sd), .phase(pd), .speed(spd_d), .ready(rdy_d));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference arithmetic: floor division, sign extension, speed model.
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint sx19(input logic [18:0] p);
        return longint'($signed(p));
    endfunction

    // avg [rad * 2^16] * scale [* 2^10] -> speed [* 2^10], floored, clamped.
    function automatic logic [15:0] speed_model(input longint avg, input longint scale);
        longint v;
        v = floor_div(avg * scale, 65536);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // One qualified sample on u_a, preceded by 'gap' idle cycles with junk phase.
    task automatic a_send(input logic [18:0] p, input int gap);
        sa = 1'b0;
        for (int g = 0; g < gap; g++) begin
            pa = 19'($urandom);
            tick();
            check("a_gap_ready", 16'(rdy_a), 16'h0);
        end
        sa = 1'b1;
        pa = p;
        tick();
        check("a_sample_ready", 16'(rdy_a), 16'h0);
        sa = 1'b0;
        pa = 19'($urandom);
    endtask

    // After the block-closing sample: ready low, then a single pulse 2 clocks on.
    task automatic a_expect(input string tag, input logic [15:0] exp);
        tick();
        check({tag, "_lat1_ready"}, 16'(rdy_a), 16'h0);
        tick();
        check({tag, "_ready"}, 16'(rdy_a), 16'h1);
        check({tag, "_speed"}, spd_a, exp);
        tick();
        check({tag, "_pulse_end"}, 16'(rdy_a), 16'h0);
        check({tag, "_hold"}, spd_a, exp);
    endtask

    longint      acc_d = 0;
    int          pulses_d = 0;
    logic [15:0] q_d[$];
    logic [15:0] exp_c [0:999];

    task automatic d_tick();
        tick();
        if (rdy_d) begin
            pulses_d++;
            if (q_d.size() == 0) check("d_unexpected_ready", 16'(rdy_d), 16'h0);
            else check("d_speed", spd_d, q_d.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b0; rst_x = 1'b0;
        sa = 1'b0; sb = 1'b0; sc = 1'b0; sd = 1'b0;
        pa = '0; pb = '0; pc = '0; pd = '0;

        // Reset state.
        tick();
        check("rst_a_speed", spd_a, 16'h0);
        check("rst_a_ready", 16'(rdy_a), 16'h0);
        check("rst_b_speed", spd_b, 16'h0);
        check("rst_b_ready", 16'(rdy_b), 16'h0);
        check("rst_c_speed", spd_c, 16'h0);
        check("rst_c_ready", 16'(rdy_c), 16'h0);
        check("rst_d_speed", spd_d, 16'h0);
        check("rst_d_ready", 16'(rdy_d), 16'h0);
        rst_a = 1'b1; rst_x = 1'b1;

        // Test 1: 1.0 rad twice -> 1.000.
        a_send(19'h10000, 0);
        a_send(19'h10000, 0);
        a_expect("t1", 16'h0400);

        // Test 2: 1.0 and 3.0 -> 2.000; then -1.0 twice -> -1.000.
        a_send(19'h10000, 0);
        a_send(19'h30000, 0);
        a_expect("t2a", 16'h0800);
        a_send(19'h70000, 0);
        a_send(19'h70000, 0);
        a_expect("t2b", 16'hFC00);

        // Test 4: three idle cycles before each sample give the same result.
        a_send(19'h10000, 3);
        a_send(19'h30000, 3);
        a_expect("t4", 16'h0800);

        // Test 5: partial block dropped by reset.
        a_send(19'h50000, 0);
        rst_a = 1'b0;
        tick();
        check("t5_rst_speed", spd_a, 16'h0);
        check("t5_rst_ready", 16'(rdy_a), 16'h0);
        rst_a = 1'b1;
        tick();
        check("t5_post_speed", spd_a, 16'h0);
        check("t5_post_ready", 16'(rdy_a), 16'h0);
        a_send(19'h10000, 0);
        a_send(19'h10000, 0);
        a_expect("t5", 16'h0400);

        // Test 3: saturation and floor on N=0, SCALE=0x3FFFF.
        sb = 1'b1; pb = 19'h3FFFF;
        tick();
        check("t3_lat0_ready", 16'(rdy_b), 16'h0);
        pb = 19'h40000;
        tick();
        check("t3_lat1_ready", 16'(rdy_b), 16'h0);
        pb = 19'h00040;
        tick();
        check("t3_max_ready", 16'(rdy_b), 16'h1);
        check("t3_max_speed", spd_b, 16'h7FFF);
        pb = 19'h7FFC0;
        tick();
        check("t3_min_ready", 16'(rdy_b), 16'h1);
        check("t3_min_speed", spd_b, 16'h8000);
        sb = 1'b0;
        tick();
        check("t3_pos_speed", spd_b, 16'h00FF);
        tick();
        check("t3_neg_speed", spd_b, 16'hFF00);
        tick();
        check("t3_end_ready", 16'(rdy_b), 16'h0);
        check("t3_hold_speed", spd_b, 16'hFF00);

        // Test 6: continuous random stream on N=0, SCALE=1.0.
        for (int i = 0; i < 1003; i++) begin
            if (i < 1000) begin
                sc = 1'b1;
                pc = 19'($urandom);
                exp_c[i] = speed_model(sx19(pc), 1024);
            end else begin
                sc = 1'b0;
                pc = 19'($urandom);
            end
            tick();
            if (i >= 2 && i < 1002) begin
                check("t6_ready", 16'(rdy_c), 16'h1);
                check("t6_speed", spd_c, exp_c[i-2]);
            end else begin
                check("t6_idle_ready", 16'(rdy_c), 16'h0);
            end
        end

        // Randomized gapped stream on N=3 with extreme phases and saturation.
        for (int blk = 0; blk < 40; blk++) begin
            for (int k = 0; k < 8; k++) begin
                int gap;
                int r;
                gap = int'($urandom_range(0, 2));
                sd = 1'b0;
                repeat (gap) begin
                    pd = 19'($urandom);
                    d_tick();
                end
                r = int'($urandom_range(0, 3));
                pd = (r == 0) ? 19'h3FFFF : (r == 1) ? 19'h40000 : 19'($urandom);
                sd = 1'b1;
                acc_d += sx19(pd);
                if (k == 7) begin
                    q_d.push_back(speed_model(floor_div(acc_d, 8), 131072));
                    acc_d = 0;
                end
                d_tick();
                sd = 1'b0;
            end
        end
        repeat (4) d_tick();
        check("d_pending", 16'(q_d.size()), 16'h0);
        check("d_pulses", 16'(pulses_d), 16'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/phase2speed.md
Name: phase2speed

Overview:
Converts a stream of signed phase-difference samples (radians, fixed point) from the Hilbert-filter/phase-difference stage into a signed speed estimate (fixed point).
- Block-averages 2^N consecutive phase samples.
- Scales the average by a constant factor.
- Saturates the result to 16 bits and emits it with a one-cycle ready pulse.
- Sits directly downstream of the phase-difference block; its output feeds the speed display/logging path.

Parameters:
N, 1, log2 of the number of phase samples averaged per output (0..8); block length L = 2^N.
SCALE, 1024, unsigned 18-bit scale factor in Q8.10 (phase-to-speed constant); 1024 = 1.0.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset.
sample  input  1  qualifier: phase is valid this cycle; may stay high every cycle.
phase  input  19  signed phase difference, Q3.16 radians (0x10000 = 1.0 rad).
speed  output  16  signed speed, Q6.10 (0x0400 = 1.0); holds last result.
ready  output  1  one-cycle pulse when speed has just been updated.

Behaviour:
- Reset: when reset==0 at a rising edge, clear the following to zero:
  - speed, ready, the accumulator, the sample counter and the pipeline valid flags.
  - Any partial block is discarded; the first block after reset starts with the next qualified sample.
- Accumulate: on each edge with sample==1 (and reset==1), add sign-extended phase to a (19+N)-bit signed accumulator and increment the counter (0..L-1).
  - Edges with sample==0 change nothing (gaps allowed).
- Block complete: on the edge taking the L-th sample:
  - avg_reg <= (acc + phase) >>> N (arithmetic shift, floor).
  - Set stage-1 valid.
  - Clear the accumulator and counter in the same edge, so the next sample starts a fresh block with no lost cycle.
- Scale (stage 2), on the next edge:
  - Compute prod = avg_reg * SCALE (signed x unsigned, 37-bit, Q11.26).
  - Shift arithmetically right by 16 (floor) to Q.10.
  - Saturate to the range [-32768, 32767] and register into speed.
  - ready <= 1 for exactly that one cycle; otherwise ready <= 0.
- Latency: ready is high in the cycle following the 2nd rising edge after the edge that captured the L-th sample (2 clocks).
- Throughput: one result per L qualified samples. With N=0 and sample always high, ready is continuously high.
- speed is stable between ready pulses; speed changes only when ready is asserted.
- No overflow in the accumulator (N guard bits). Saturation applies only at the output.

Decomposition:
- Shared package phase2speed_pkg:
  - Widths: PHASE_W=19, PHASE_FRAC=16, SPEED_W=16, SPEED_FRAC=10, SCALE_W=18, SCALE_FRAC=10.
  - Saturation limits SPEED_MAX=32767 and SPEED_MIN=-32768.
- One natural sub-module, phase_block_avg:
  - Handles counter, accumulator and the avg_reg/valid outputs.
  - Top level holds the multiplier, shift, saturation and output registers.

Test Plan:
1. N=1, SCALE=1024, reset low one cycle then high; phase 0x10000, 0x10000 with sample high -> ready pulses 2 clocks after the 2nd sample; speed=0x0400 (1.000).
2. N=1: phase 0x10000 then 0x30000 -> speed=0x0800 (2.000). Next block -0x10000 twice (0x70000 as 19-bit) -> speed=0xFC00 (-1.000). One ready per block.
3. Saturation, N=0, SCALE=0x3FFFF: phase 0x3FFFF -> speed=0x7FFF; phase 0x40000 -> speed=0x8000.
4. Gaps, N=1: samples separated by 3 sample-low cycles -> same result as back-to-back. ready occurs 2 clocks after the 2nd qualified sample only.
5. Reset mid-block, N=1: one sample 0x50000, assert reset, then 0x10000, 0x10000 -> speed=0x0400; ready and speed are 0 during and immediately after reset.
6. Continuous streaming, N=0, SCALE=1024, random phases for 1000 cycles -> every cycle after 2-cycle latency: speed == floor(phase/64), within saturation; mean relative error vs reference model 0 %.
